// File: rtl/keypad_time_entry.sv
// Debounces the keypad encoder output, accepts one digit per key press and
// shifts accepted digits into a 4-digit BCD MM:SS cooking-time register.
module keypad_time_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [3:0]  digit,
   input  logic        validn,
   input  logic        enablen,
   input  logic        clearn,
   output logic [15:0] time_bcd,
   output logic [2:0]  entry_count,
   output logic        key_pulse,
   output logic        time_valid
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

   localparam logic [7:0] DC = 8'(DEBOUNCE_CYCLES);

   state_t      state_q, state_d;
   logic [3:0]  cand_q, cand_d;
   logic [7:0]  dcnt_q, dcnt_d;
   logic [15:0] time_q, time_d;
   logic [2:0]  count_q, count_d;
   logic        pulse_q, pulse_d;

   logic        digit_ok;
   logic [7:0]  dcnt_inc;

   assign digit_ok = (digit <= 4'd9);
   // The stable-sample counter saturates rather than wrapping.
   assign dcnt_inc = (dcnt_q == 8'hFF) ? dcnt_q : dcnt_q + 8'd1;

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      dcnt_d  = dcnt_q;
      time_d  = time_q;
      count_d = count_q;
      pulse_d = 1'b0;
      if (!clearn) begin
         time_d  = 16'h0000;
         count_d = 3'd0;
         state_d = IDLE;
         dcnt_d  = 8'd0;
      end else if (enablen) begin
         state_d = IDLE;
         dcnt_d  = 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!validn && digit_ok) begin
                  cand_d  = digit;
                  dcnt_d  = 8'd1;
                  state_d = DEBOUNCE;
               end
            end
            DEBOUNCE: begin
               if (validn || !digit_ok) begin
                  state_d = IDLE;
                  dcnt_d  = 8'd0;
               end else if (digit != cand_q) begin
                  cand_d = digit;
                  dcnt_d = 8'd1;
               end else begin
                  dcnt_d = dcnt_inc;
                  if (dcnt_inc >= DC) begin
                     // A fifth digit is swallowed but the key still has to be released.
                     state_d = HELD;
                     if (count_q < 3'd4) begin
                        time_d  = {time_q[11:0], cand_q};
                        count_d = count_q + 3'd1;
                        pulse_d = 1'b1;
                     end
                  end
               end
            end
            HELD: begin
               if (validn) begin
                  state_d = IDLE;
                  dcnt_d  = 8'd0;
               end
            end
            default: begin
               state_d = IDLE;
               dcnt_d  = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cand_q  <= 4'd0;
         dcnt_q  <= 8'd0;
         time_q  <= 16'h0000;
         count_q <= 3'd0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         dcnt_q  <= dcnt_d;
         time_q  <= time_d;
         count_q <= count_d;
         pulse_q <= pulse_d;
      end
   end

   assign time_bcd    = time_q;
   assign entry_count = count_q;
   assign key_pulse   = pulse_q;
   assign time_valid  = (count_q != 3'd0) && (time_q[7:4] <= 4'd5);

endmodule

// File: tb/tb_keypad_time_entry.sv
// Randomized and directed bench for keypad_time_entry: a key-press level model
// predicts accepted digits; a monitor checks every strobe and every cycle.
module tb_keypad_time_entry;

   localparam int D = 4;

   logic        clock = 1'b0;
   logic        resetn = 1'b1;
   logic [3:0]  digit = 4'd0;
   logic        validn = 1'b1;
   logic        enablen = 1'b0;
   logic        clearn = 1'b1;
   logic [15:0] time_bcd;
   logic [2:0]  entry_count;
   logic        key_pulse;
   logic        time_valid;

   keypad_time_entry #(.DEBOUNCE_CYCLES(D)) dut (
      .clock(clock), .resetn(resetn), .digit(digit), .validn(validn),
      .enablen(enablen), .clearn(clearn), .time_bcd(time_bcd),
      .entry_count(entry_count), .key_pulse(key_pulse), .time_valid(time_valid)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   int pulses_seen = 0;

   // Reference model: list of accepted digits plus press bookkeeping.
   logic [3:0]  digs[$];
   logic [15:0] exp_q[$];
   bit          armed = 1'b1;
   int          run = 0;
   logic [3:0]  last_digit = 4'd0;

   function automatic logic [15:0] mdl_time();
      logic [15:0] t = 16'h0000;
      foreach (digs[i]) t = {t[11:0], digs[i]};
      return t;
   endfunction

   function automatic logic mdl_valid();
      logic [15:0] t = mdl_time();
      return (digs.size() != 0) && (t[7:4] <= 4'd5);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      digs.delete();
      exp_q.delete();
      armed = 1'b1;
      run = 0;
   endtask

   // One sampled edge as seen at the key-press level.
   task automatic model_edge(input logic [3:0] d, input logic v, input logic en, input logic clr);
      if (!clr) begin
         digs.delete();
         armed = 1'b1;
         run = 0;
      end else if (en) begin
         armed = 1'b1;
         run = 0;
      end else if (!armed) begin
         if (v) armed = 1'b1;
         run = 0;
      end else if (v || d > 4'd9) begin
         run = 0;
      end else begin
         if (run > 0 && d == last_digit) run++;
         else run = 1;
         last_digit = d;
         if (run == D) begin
            armed = 1'b0;
            run = 0;
            if (digs.size() < 4) begin
               digs.push_back(d);
               exp_q.push_back(mdl_time());
            end
         end
      end
   endtask

   task automatic step(input logic [3:0] d, input logic v, input logic en, input logic clr);
      digit = d; validn = v; enablen = en; clearn = clr;
      @(posedge clock);
      model_edge(d, v, en, clr);
      #1;
   endtask

   task automatic press(input logic [3:0] d, input int len, input int gap);
      for (int i = 0; i < len; i++) step(d, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < gap; i++) step(d, 1'b1, 1'b0, 1'b1);
   endtask

   // Monitor: strobes must match the scoreboard exactly in time and value.
   always @(negedge clock) begin
      if (resetn) begin
         if (key_pulse) begin
            pulses_seen++;
            if (exp_q.size() == 0) begin
               chk("unexpected_key_pulse", 16'(key_pulse), 16'd0);
            end else begin
               chk("pulse_time_bcd", time_bcd, exp_q.pop_front());
            end
         end else if (exp_q.size() != 0) begin
            chk("missing_key_pulse", 16'(key_pulse), 16'd1);
            void'(exp_q.pop_front());
         end
         chk("time_bcd", time_bcd, mdl_time());
         chk("entry_count", 16'(entry_count), 16'(digs.size()));
         chk("time_valid", 16'(time_valid), 16'(mdl_valid()));
      end
   end

   initial begin
      int p0;
      #1 resetn = 1'b0;
      #2;
      chk("reset_time_bcd", time_bcd, 16'h0000);
      chk("reset_entry_count", 16'(entry_count), 16'd0);
      chk("reset_key_pulse", 16'(key_pulse), 16'd0);
      chk("reset_time_valid", 16'(time_valid), 16'd0);
      #9 resetn = 1'b1;
      @(posedge clock); #1;

      // Single key
      press(4'd7, 4, 2);
      chk("single_time", time_bcd, 16'h0007);
      chk("single_count", 16'(entry_count), 16'd1);
      chk("single_valid", 16'(time_valid), 16'd1);

      // Four digits then overflow
      step(4'd0, 1'b1, 1'b0, 1'b0);
      press(4'd1, 4, 2); press(4'd2, 4, 1); press(4'd3, 5, 2); press(4'd0, 4, 2);
      chk("four_time", time_bcd, 16'h1230);
      chk("four_count", 16'(entry_count), 16'd4);
      p0 = pulses_seen;
      press(4'd9, 6, 2);
      chk("overflow_time", time_bcd, 16'h1230);
      chk("overflow_no_pulse", 16'(pulses_seen - p0), 16'd0);

      // Bounce rejection
      step(4'd0, 1'b1, 1'b0, 1'b0);
      press(4'd8, 3, 1); press(4'd8, 3, 2);
      chk("bounce_count", 16'(entry_count), 16'd0);
      press(4'd5, 2, 0); press(4'd6, 4, 2);
      chk("retoggle_time", time_bcd, 16'h0006);

      // Hold without repeat
      step(4'd0, 1'b1, 1'b0, 1'b0);
      p0 = pulses_seen;
      press(4'd4, 50, 2);
      chk("hold_pulses", 16'(pulses_seen - p0), 16'd1);
      chk("hold_count", 16'(entry_count), 16'd1);

      // Clear on the commit edge
      for (int i = 0; i < 3; i++) step(4'd8, 1'b0, 1'b0, 1'b1);
      step(4'd8, 1'b0, 1'b0, 1'b0);
      chk("collide_time", time_bcd, 16'h0000);
      chk("collide_count", 16'(entry_count), 16'd0);
      chk("collide_pulse", 16'(key_pulse), 16'd0);
      step(4'd8, 1'b1, 1'b0, 1'b1);
      press(4'd0, 4, 2); press(4'd7, 4, 2); press(4'd5, 4, 2);
      chk("075_time", time_bcd, 16'h0075);
      chk("075_valid", 16'(time_valid), 16'd0);

      // Enable abort during debounce
      step(4'd3, 1'b0, 1'b0, 1'b1); step(4'd3, 1'b0, 1'b0, 1'b1);
      step(4'd3, 1'b0, 1'b1, 1'b1);
      press(4'd3, 2, 2);
      chk("enable_time", time_bcd, 16'h0075);
      chk("enable_count", 16'(entry_count), 16'd3);

      // Reset while held, key still down afterwards
      for (int i = 0; i < 8; i++) step(4'd9, 1'b0, 1'b0, 1'b1);
      chk("held_time", time_bcd, 16'h0759);
      resetn = 1'b0;
      model_reset();
      #2;
      chk("async_rst_time", time_bcd, 16'h0000);
      chk("async_rst_count", 16'(entry_count), 16'd0);
      chk("async_rst_pulse", 16'(key_pulse), 16'd0);
      chk("async_rst_valid", 16'(time_valid), 16'd0);
      #1 resetn = 1'b1;
      press(4'd2, 4, 2);
      chk("after_rst_time", time_bcd, 16'h0002);

      // Randomized sessions
      repeat (400) begin
         int r = $urandom_range(0, 99);
         if (r < 5 || (digs.size() == 4 && r < 40)) begin
            step(4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
         end else if (r < 10) begin
            logic [3:0] d = 4'($urandom_range(0, 9));
            for (int i = 0; i < $urandom_range(0, 3); i++) step(d, 1'b0, 1'b0, 1'b1);
            step(d, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
         end else begin
            logic [3:0] d = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                         : 4'($urandom_range(0, 9));
            int len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
               if ($urandom_range(0, 9) == 0) d = 4'($urandom_range(0, 9));
               step(d, 1'b0, 1'b0, 1'b1);
            end
            for (int i = 0; i < $urandom_range(1, 3); i++) step(d, 1'b1, 1'b0, 1'b1);
         end
      end
      step(4'd0, 1'b1, 1'b0, 1'b1);
      step(4'd0, 1'b1, 1'b0, 1'b1);
      chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/keypad_time_entry.md
# keypad_time_entry

Sequential stage downstream of the keypad priority encoder. It debounces the encoder's `digit`/`validn` pair and accepts exactly one digit per key press. Accepted digits shift into a 4-digit BCD MM:SS cooking-time register, which is presented to the countdown timer. It also flags when the entered time is well-formed.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive samples with `validn` low and a stable `digit` required to accept a key. Legal range is 2..255.
- `clock`  in  1  single system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `digit`  in  4  encoded key value from the encoder; BCD 0..9.
- `validn`  in  1  active-low key-valid from the encoder.
- `enablen`  in  1  active-low entry enable; the same signal that gates the encoder.
- `clearn`  in  1  synchronous, active-low clear of the entered time.
- `time_bcd`  out  16  {min_tens, min_ones, sec_tens, sec_ones}, each nibble BCD.
- `entry_count`  out  3  number of digits entered, 0..4.
- `key_pulse`  out  1  one-cycle strobe on each accepted digit.
- `time_valid`  out  1  high when `entry_count` is nonzero and sec_tens is 5 or less.

## Operation
- The FSM has three states: IDLE, DEBOUNCE and HELD.
- **IDLE**
  - A sample with `validn`=0 and `digit`≤9 captures `digit` into `cand`, sets `dcnt`=1 and moves to DEBOUNCE.
- **DEBOUNCE**
  - `validn`=1 returns to IDLE; nothing is committed.
  - `digit` differs from `cand`: recapture `cand`, set `dcnt`=1 and stay in DEBOUNCE.
  - `digit`>9: return to IDLE.
  - Otherwise increment `dcnt`. The sample on which `dcnt` reaches `DEBOUNCE_CYCLES` commits the digit and moves to HELD.
- **Commit**
  - If `entry_count`<4: `time_bcd` ← {`time_bcd`[11:0], `cand`}, `entry_count` +1, `key_pulse`=1 for the following cycle.
  - If `entry_count`=4: the digit is discarded. `time_bcd` and `entry_count` are unchanged, no `key_pulse` is produced, and the FSM still goes to HELD.
- **HELD**
  - Remains in HELD while `validn`=0, whatever `digit` does; there is no auto-repeat.
  - The first sample with `validn`=1 returns to IDLE.
- A leading 0 is a normal digit: it shifts in and is counted.
- **`enablen`=1**
  - Forces the FSM to IDLE and clears `dcnt` on the next edge.
  - No commit occurs; `time_bcd` and `entry_count` are held.
- **`clearn`=0**
  - On the next edge: `time_bcd`=0, `entry_count`=0, FSM→IDLE, `key_pulse`=0.
  - Clear has priority over a commit on the same edge.
- `time_valid` is combinational from the registered outputs. Minutes are unbounded, so 99:59 is valid and 12:60 is invalid.

## Timing
- **Reset values:** `time_bcd`=16'h0000, `entry_count`=0, `key_pulse`=0, `time_valid`=0, FSM in IDLE, `dcnt`=0, `cand`=0.
- Reset assertion mid-press or mid-debounce discards the press. After release, a key that is still held is treated as a new press starting from IDLE.
- Inputs are synchronous to `clock` and sampled at each rising edge.
- **Accept latency:** the press is first sampled at edge k, and the commit happens at edge k+`DEBOUNCE_CYCLES`−1. `time_bcd`, `entry_count` and `key_pulse` update after that edge. `key_pulse` drops after the next edge.
- **Re-arm latency:** after `validn` returns high, at least one sample must show `validn`=1. The next press can then be sampled on the following edge at the earliest.
- `dcnt` width is 8 bits. `dcnt` saturates and never wraps.

## Test plan
- **Single key:** reset, then hold digit 7 with `validn`=0 for 4 cycles (D=4). Expect `key_pulse` for exactly one cycle, `time_bcd`=16'h0007, `entry_count`=1, `time_valid`=1.
- **Four-digit entry and overflow:** press 1,2,3,0 with release gaps, giving `time_bcd`=16'h1230 and `entry_count`=4. A fifth press of 9 then gives no `key_pulse` and `time_bcd` stays 16'h1230.
- **Bounce rejection:**
  - Low 3 cycles, high 1, low 3: no commit.
  - `digit` toggling 5→6 on the third cycle restarts the count; commit 6 after 4 stable cycles.
- **Hold without repeat:** hold digit 4 low for 50 cycles. Expect exactly one `key_pulse` and `entry_count`=1.
- **Clear vs. commit collision:** `clearn`=0 on the commit edge gives `time_bcd`=0, `entry_count`=0 and no `key_pulse`. An entry of 0,7,5 gives 16'h0075 with `time_valid`=0.
- **Enable and reset mid-operation:**
  - `enablen`=1 during DEBOUNCE aborts the press with the value retained.
  - `resetn` pulsed low in HELD gives all outputs at reset values asynchronously.
